pw_bit_rx: RTL
==============

// Module: pw_bit_rx
// PURPOSE
//  Pulse-width bit receiver: decodes one serial line of high-pulse-width-coded bits (short high = 0,
//  long high = 1, long low gap = frame end) into DATA_WIDTH-bit words with a frame-last flag.
//  Counterpart of the axi_pw_bit transmitter channel; sits between an input pin and a
//  valid/ready stream consumer. Timing thresholds arrive on static cfg_* ports from a register block.
// PARAMETERS
//  DATA_WIDTH   32  bits per output word (max)
//  CNT_WIDTH    16  width of pulse/gap cycle counters and cfg timing ports
//  FIFO_DEPTH   4   output FIFO entries (power of 2, >=2)
// PORTS
//  aclk          in   1           clock
//  areset        in   1           asynchronous active-high reset
//  rxd           in   1           serial input, asynchronous to aclk, idles low
//  cfg_thresh    in   CNT_WIDTH   high cycles >= cfg_thresh -> bit 1, else bit 0
//  cfg_min_high  in   CNT_WIDTH   high pulses shorter than this are errors
//  cfg_idle      in   CNT_WIDTH   low (or stuck-high) cycles that end a frame
//  cfg_nbits     in   6           bits per word; 0 or >DATA_WIDTH means DATA_WIDTH
//  m_data        out  DATA_WIDTH  received word, first bit received in MSB of used field, right-aligned
//  m_last        out  1           word is the final word of its frame
//  m_valid       out  1           FIFO head valid
//  m_ready       in   1           consumer accepts head
//  err_pulse     out  1           1-cycle pulse: runt or stuck-high pulse
//  err_frame     out  1           1-cycle pulse: frame ended with partial word
//  err_overflow  out  1           1-cycle pulse: word dropped, FIFO full
//  busy          out  1           FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, staging empty, FSM IDLE, synchronizer flops 0. Reset mid-frame
//    discards all partial and staged data; no word emitted.
//  - rxd passes a 2-flop synchronizer (s); edges detected on s vs s_d. Pin-to-FSM latency 2 cycles.
//  - cfg_* latched on IDLE->HIGH transition; held constant for the whole frame.
//  - Counters hcnt/lcnt CNT_WIDTH, saturate at all-ones, unsigned compares.
//  - FSM:
//    IDLE: s rise -> HIGH, hcnt=1, bitcnt=0, shift=0.
//    HIGH: hcnt++. s fall: hcnt<cfg_min_high -> err_pulse, -> DRAIN; else shift in (hcnt>=cfg_thresh),
//          bitcnt++, -> LOW, lcnt=1. hcnt reaches cfg_idle while high -> err_pulse, -> DRAIN.
//    LOW:  lcnt++. s rise -> HIGH, hcnt=1. lcnt reaches cfg_idle -> frame end, -> IDLE.
//    DRAIN: wait until s low for cfg_idle consecutive cycles, then frame end, -> IDLE.
//  - Word complete (bitcnt==nbits on fall edge): if staging full, push staged word with last=0;
//    new word enters staging; bitcnt=0. Push and staging load occur on the same clock edge.
//  - Frame end: staged word (if any) pushed with last=1; bitcnt!=0 -> err_frame, partial discarded.
//    m_valid rises 1 cycle after push; i.e. last word visible cfg_idle+3 cycles after final pin fall.
//  - Frame with zero complete words emits nothing.
//  - FIFO: stores {last,data}, show-ahead; pop when m_valid&m_ready. Push when full and no pop in same
//    cycle -> word dropped, err_overflow. Push+pop in same cycle at full -> both accepted.
//  - busy = (state != IDLE) | staging full.
// CONFIGURATION
//  PW_BIT_RX_DEGLITCH_EN defined: 3-tap majority filter after synchronizer; filtered line drives the
//   FSM; isolated 1-cycle spikes of either polarity suppressed; pin-to-FSM latency 4 cycles.
//  Not defined: synchronizer output drives FSM directly; latency 2; no filtering.
// TESTING (cfg_thresh=60, cfg_min_high=10, cfg_idle=200, cfg_nbits=8; tx: bit 0 = 40 high, bit 1 = 80 high, period 125)
//  1. Send 0xA5 then 300 low -> one word m_data=0x000000A5, m_last=1; m_valid within 203 cycles of last fall.
//  2. Send 0x12,0x34 in one frame -> 0x12 last=0 then 0x34 last=1; no err_* pulses.
//  3. 5-cycle high glitch mid-word -> err_pulse once, no word; next frame 0x5A after gap decodes correctly.
//  4. m_ready=0, five 1-word frames -> 4 held, err_overflow exactly once; drain yields first four in order.
//  5. 5 bits then 300 low -> err_frame once, no word, busy falls to 0.
//  6. areset asserted after 3 bits of word -> all outputs 0 immediately; next frame 0xC3 decodes cleanly.
//  7. rxd held high 500 cycles -> err_pulse once at hcnt=200; nothing emitted; IDLE 200 cycles after fall.
//  8. With PW_BIT_RX_DEGLITCH_EN: 1-cycle low spike inside a 1-bit -> no error, word unchanged.

Source files
------------

// File: rtl/pw_bit_rx_if.sv
// Output stream bundle of the pulse-width bit receiver: word data, frame-last
// flag and the valid/ready handshake. The receiver drives it as master.
interface pw_bit_rx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, m_last, m_valid, input m_ready);
  modport slave  (input  m_data, m_last, m_valid, output m_ready);
endinterface

// File: rtl/pw_bit_rx.sv
// pw_bit_rx: pulse-width bit receiver. Decodes high-pulse-width coded bits
// (short high = 0, long high = 1, long low = frame end) into words that are
// queued in a small show-ahead FIFO with a frame-last flag.
// Optional build macro PW_BIT_RX_DEGLITCH_EN inserts a 3-tap majority filter
// after the synchronizer (pin-to-FSM latency 4 instead of 2 cycles).
module pw_bit_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 rxd,
  input  logic [CNT_WIDTH-1:0] cfg_thresh,
  input  logic [CNT_WIDTH-1:0] cfg_min_high,
  input  logic [CNT_WIDTH-1:0] cfg_idle,
  input  logic [5:0]           cfg_nbits,
  pw_bit_rx_if.master          m_axis,
  output logic                 err_pulse,
  output logic                 err_frame,
  output logic                 err_overflow,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------- input conditioning ----------------
  logic sync1_q, sync2_q, line, line_d_q, rise, fall;

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

`ifdef PW_BIT_RX_DEGLITCH_EN
  logic tap1_q, tap2_q, filt_q;
  // Majority of three consecutive samples removes isolated 1-cycle spikes
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tap1_q <= 1'b0;
      tap2_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
      filt_q <= (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
    end
  end
  assign line = filt_q;
`else
  assign line = sync2_q;
`endif

  // Delayed copy of the conditioned line for edge detection
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) line_d_q <= 1'b0;
    else        line_d_q <= line;
  end

  assign rise = line & ~line_d_q;
  assign fall = ~line & line_d_q;

  // ---------------- decoder FSM ----------------
  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [CNT_WIDTH-1:0]  thr_q, thr_d, minh_q, minh_d, idle_q, idle_d;
  logic [6:0]            nbits_q, nbits_d, bitcnt_q, bitcnt_d, nbits_eff;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, stage_q, stage_d, new_shift;
  logic                  stage_vld_q, stage_vld_d;
  logic                  err_pulse_q, err_pulse_d, err_frame_q, err_frame_d;
  logic                  frame_end, push, push_last;

  // 0 or an oversize request selects the full word width
  assign nbits_eff = (cfg_nbits == 6'd0 || int'(cfg_nbits) > DATA_WIDTH)
                     ? 7'(DATA_WIDTH) : {1'b0, cfg_nbits};
  assign new_shift = {shift_q[DATA_WIDTH-2:0], (hcnt_q >= thr_q)};

  // Next-state logic: pulse measurement, bit assembly and word staging
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    thr_d       = thr_q;
    minh_d      = minh_q;
    idle_d      = idle_q;
    nbits_d     = nbits_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    err_pulse_d = 1'b0;
    err_frame_d = 1'b0;
    frame_end   = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d  = S_HIGH;
          hcnt_d   = CNT_WIDTH'(1);
          bitcnt_d = '0;
          shift_d  = '0;
          thr_d    = cfg_thresh;
          minh_d   = cfg_min_high;
          idle_d   = cfg_idle;
          nbits_d  = nbits_eff;
        end
      end
      S_HIGH: begin
        if (fall) begin
          lcnt_d = CNT_WIDTH'(1);
          if (hcnt_q < minh_q) begin
            err_pulse_d = 1'b1;
            state_d     = S_DRAIN;
          end else begin
            state_d = S_LOW;
            if (bitcnt_q + 7'd1 == nbits_q) begin
              // Previous staged word is not the frame's last; new word replaces it
              push        = stage_vld_q;
              stage_d     = new_shift;
              stage_vld_d = 1'b1;
              bitcnt_d    = '0;
              shift_d     = '0;
            end else begin
              shift_d  = new_shift;
              bitcnt_d = bitcnt_q + 7'd1;
            end
          end
        end else if (hcnt_q >= idle_q) begin
          err_pulse_d = 1'b1;
          state_d     = S_DRAIN;
          lcnt_d      = '0;
        end else begin
          hcnt_d = sat_inc(hcnt_q);
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = CNT_WIDTH'(1);
        end else if (lcnt_q >= idle_q) begin
          frame_end = 1'b1;
        end else begin
          lcnt_d = sat_inc(lcnt_q);
        end
      end
      default: begin // S_DRAIN: need an unbroken low stretch
        if (line)                  lcnt_d    = '0;
        else if (lcnt_q >= idle_q) frame_end = 1'b1;
        else                       lcnt_d    = sat_inc(lcnt_q);
      end
    endcase
    if (frame_end) begin
      state_d     = S_IDLE;
      push        = stage_vld_q;
      push_last   = 1'b1;
      stage_vld_d = 1'b0;
      err_frame_d = (bitcnt_q != 7'd0);
      bitcnt_d    = '0;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      thr_q       <= '0;
      minh_q      <= '0;
      idle_q      <= '0;
      nbits_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      thr_q       <= thr_d;
      minh_q      <= minh_d;
      idle_q      <= idle_d;
      nbits_q     <= nbits_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      err_pulse_q <= err_pulse_d;
      err_frame_q <= err_frame_d;
    end
  end

  // ---------------- output FIFO ----------------
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic                fifo_valid, fifo_full, pop, push_ok, ovf, err_ovf_q;

  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop        = fifo_valid & m_axis.m_ready;
  assign push_ok    = push & (~fifo_full | pop);
  assign ovf        = push & fifo_full & ~pop;

  // Occupancy bookkeeping
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  // Pointers, occupancy and overflow pulse
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      err_ovf_q <= ovf;
    end
  end

  // Storage array; contents are only meaningful while counted as occupied
  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, (push_last ? stage_q : stage_q)};
  end

  assign m_axis.m_valid = fifo_valid;
  assign m_axis.m_data  = fifo_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign m_axis.m_last  = fifo_valid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;
  assign err_pulse      = err_pulse_q;
  assign err_frame      = err_frame_q;
  assign err_overflow   = err_ovf_q;
  assign busy           = (state_q != S_IDLE) | stage_vld_q;

endmodule
